// File: rtl/rxfifo_pkg.sv
// Shared definitions for the Rx receive buffer and the bus register block.
// Latency: n/a (constants only).
// Backpressure: n/a.
package rxfifo_pkg;

  // Default geometry of the receive buffer
  localparam int RXFIFO_DEPTH     = 8;
  localparam int RXFIFO_IRQ_LEVEL = 4;

  // Bit positions of the Rx status word as seen by the bus register block
  localparam int RX_STAT_EMPTY   = 0;
  localparam int RX_STAT_FULL    = 1;
  localparam int RX_STAT_OVERRUN = 2;
  localparam int RX_STAT_IRQ     = 3;

  typedef struct packed {
    logic irq;
    logic overrun;
    logic full;
    logic empty;
  } rx_stat_t;

endpackage

// File: rtl/rxfifo.sv
// Rx receive buffer: first-word-fall-through byte FIFO between Rx shifter and bus.
// Latency: a written byte is visible on o_Data / o_Count one cycle after i_Rx_Done.
// Backpressure: none upstream; a byte arriving while full (and not popped) is dropped and flags overrun.
//
// Ports:
//   i_Pclk, i_Reset        clock, synchronous active-high reset
//   i_Rx_Data, i_Rx_Done   byte and one-cycle write strobe from the Rx shifter
//   i_Read                 pop strobe from the bus side
//   i_Flush                discard all contents
//   i_Clr_Overrun          clear sticky overrun flag
//   o_Data                 head entry (0 while empty)
//   o_Empty, o_Full        fill status
//   o_Count                fill level
//   o_Overrun              sticky drop flag
//   o_Irq                  fill level >= IRQ_LEVEL
module rxfifo
  import rxfifo_pkg::*;
#(
  parameter int DEPTH     = RXFIFO_DEPTH,
  parameter int IRQ_LEVEL = RXFIFO_IRQ_LEVEL
) (
  input  logic                     i_Pclk,
  input  logic                     i_Reset,
  input  logic [7:0]               i_Rx_Data,
  input  logic                     i_Rx_Done,
  input  logic                     i_Read,
  input  logic                     i_Flush,
  input  logic                     i_Clr_Overrun,
  output logic [7:0]               o_Data,
  output logic                     o_Empty,
  output logic                     o_Full,
  output logic [$clog2(DEPTH):0]   o_Count,
  output logic                     o_Overrun,
  output logic                     o_Irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overrun;

  logic full;
  logic empty;
  logic wr_en;
  logic rd_en;
  logic drop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A full buffer still accepts a byte when the head is popped in the same
  // cycle; an empty buffer ignores the pop. Flush discards everything.
  assign wr_en = i_Rx_Done && (!full || i_Read) && !i_Flush;
  assign rd_en = i_Read && !empty && !i_Flush;
  assign drop  = i_Rx_Done && full && !i_Read && !i_Flush;

  // Storage is deliberately not reset; o_Data masks stale contents.
  always_ff @(posedge i_Pclk) begin
    if (wr_en) begin
      mem[wr_ptr] <= i_Rx_Data;
    end
  end

  always_ff @(posedge i_Pclk) begin
    if (i_Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overrun: a same-cycle drop beats the clear; flush leaves it alone.
  always_ff @(posedge i_Pclk) begin
    if (i_Reset) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (i_Clr_Overrun) begin
      overrun <= 1'b0;
    end
  end

  assign o_Data    = empty ? 8'h00 : mem[rd_ptr];
  assign o_Empty   = empty;
  assign o_Full    = full;
  assign o_Count   = count;
  assign o_Overrun = overrun;
  assign o_Irq     = (count >= CW'(IRQ_LEVEL));

endmodule

// File: tb/tb_rxfifo.sv
// Self-checking bench for rxfifo using a queue scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_rxfifo;

  logic       i_Pclk = 1'b0;
  logic       i_Reset;
  logic [7:0] i_Rx_Data;
  logic       i_Rx_Done;
  logic       i_Read;
  logic       i_Flush;
  logic       i_Clr_Overrun;
  logic [7:0] o_Data;
  logic       o_Empty;
  logic       o_Full;
  logic [3:0] o_Count;
  logic       o_Overrun;
  logic       o_Irq;

  rxfifo #(.DEPTH(8), .IRQ_LEVEL(4)) dut (
    .i_Pclk        (i_Pclk),
    .i_Reset       (i_Reset),
    .i_Rx_Data     (i_Rx_Data),
    .i_Rx_Done     (i_Rx_Done),
    .i_Read        (i_Read),
    .i_Flush       (i_Flush),
    .i_Clr_Overrun (i_Clr_Overrun),
    .o_Data        (o_Data),
    .o_Empty       (o_Empty),
    .o_Full        (o_Full),
    .o_Count       (o_Count),
    .o_Overrun     (o_Overrun),
    .o_Irq         (o_Irq)
  );

  always #5 i_Pclk = ~i_Pclk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] sb_q[$];
  logic       m_ovr;
  logic [7:0] exp_pop;
  logic [7:0] got_pop;
  logic       did_pop;

  // Drive one cycle of stimulus and advance the reference model.
  // Inputs change #1 after an edge; outputs are sampled #1 after the next edge.
  task automatic step(input logic done, input logic [7:0] d, input logic rd,
                      input logic fl = 1'b0, input logic clr = 1'b0);
    logic m_full;
    logic m_empty;
    i_Rx_Done     = done;
    i_Rx_Data     = d;
    i_Read        = rd;
    i_Flush       = fl;
    i_Clr_Overrun = clr;
    got_pop = o_Data;
    did_pop = 1'b0;
    m_full  = (sb_q.size() == 8);
    m_empty = (sb_q.size() == 0);
    if (fl) begin
      sb_q.delete();
    end else begin
      if (rd && !m_empty) begin
        exp_pop = sb_q.pop_front();
        did_pop = 1'b1;
      end
      if (done && (!m_full || rd)) sb_q.push_back(d);
    end
    if (!fl && done && m_full && !rd) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    @(posedge i_Pclk);
    #1;
    i_Rx_Done = 1'b0; i_Read = 1'b0; i_Flush = 1'b0; i_Clr_Overrun = 1'b0;
    i_Rx_Data = 8'h00;
  endtask

  task automatic do_reset();
    i_Reset = 1'b1;
    i_Rx_Done = 1'b0; i_Read = 1'b0; i_Flush = 1'b0; i_Clr_Overrun = 1'b0;
    i_Rx_Data = 8'h00;
    repeat (2) @(posedge i_Pclk);
    #1;
    i_Reset = 1'b0;
    sb_q.delete();
    m_ovr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    step(1'b0, 8'h00, 1'b0);
    n_cmp++; if (o_Empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%b want=1", o_Empty); end
    n_cmp++; if (o_Count !== 4'd0) begin n_err++; $display("FAIL reset_count got=%0d want=0", o_Count); end
    n_cmp++; if (o_Data !== 8'h00) begin n_err++; $display("FAIL reset_data got=%h want=00", o_Data); end
    n_cmp++; if (o_Irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b want=0", o_Irq); end
    n_cmp++; if (o_Full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b want=0", o_Full); end
    n_cmp++; if (o_Overrun !== 1'b0) begin n_err++; $display("FAIL reset_ovr got=%b want=0", o_Overrun); end
  endtask

  task automatic test_basic();
    logic [7:0] pat [3];
    pat[0] = 8'hA5; pat[1] = 8'h3C; pat[2] = 8'hFF;
    step(1'b1, pat[0], 1'b0);
    n_cmp++; if (o_Data !== 8'hA5) begin n_err++; $display("FAIL basic_first_head got=%h want=a5", o_Data); end
    step(1'b1, pat[1], 1'b0);
    step(1'b1, pat[2], 1'b0);
    n_cmp++; if (o_Count !== 4'(sb_q.size())) begin n_err++; $display("FAIL basic_count got=%0d want=%0d", o_Count, sb_q.size()); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1);
      n_cmp++; if (!did_pop || got_pop !== exp_pop || got_pop !== pat[i]) begin
        n_err++; $display("FAIL basic_pop%0d got=%h want=%h", i, got_pop, pat[i]);
      end
    end
    n_cmp++; if (o_Empty !== 1'b1 || o_Data !== 8'h00) begin n_err++; $display("FAIL basic_empty got=%b/%h want=1/00", o_Empty, o_Data); end
    step(1'b0, 8'h00, 1'b1);
    n_cmp++; if (o_Count !== 4'd0 || o_Overrun !== 1'b0) begin n_err++; $display("FAIL basic_underflow got=%0d/%b want=0/0", o_Count, o_Overrun); end
  endtask

  task automatic test_fill_overrun();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i), 1'b0);
      n_cmp++; if (o_Irq !== (sb_q.size() >= 4) || o_Count !== 4'(sb_q.size())) begin
        n_err++; $display("FAIL fill_irq%0d got=%b/%0d want=%b/%0d", i, o_Irq, o_Count, sb_q.size() >= 4, sb_q.size());
      end
    end
    n_cmp++; if (o_Full !== 1'b1) begin n_err++; $display("FAIL fill_full got=%b want=1", o_Full); end
    step(1'b1, 8'h09, 1'b0);
    n_cmp++; if (o_Overrun !== m_ovr || o_Count !== 4'd8) begin n_err++; $display("FAIL fill_overrun got=%b/%0d want=%b/8", o_Overrun, o_Count, m_ovr); end
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 8'h00, 1'b1);
      n_cmp++; if (got_pop !== exp_pop || got_pop !== 8'(i)) begin n_err++; $display("FAIL fill_pop%0d got=%h want=%h", i, got_pop, 8'(i)); end
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (o_Overrun !== 1'b0 || o_Empty !== 1'b1) begin n_err++; $display("FAIL fill_clr got=%b/%b want=0/1", o_Overrun, o_Empty); end
  endtask

  task automatic test_full_rw();
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'h55, 1'b1);
    n_cmp++; if (o_Count !== 4'd8 || o_Overrun !== 1'b0) begin n_err++; $display("FAIL fullrw_state got=%0d/%b want=8/0", o_Count, o_Overrun); end
    n_cmp++; if (got_pop !== 8'h01) begin n_err++; $display("FAIL fullrw_pop got=%h want=01", got_pop); end
    while (sb_q.size() > 0) begin
      step(1'b0, 8'h00, 1'b1);
      n_cmp++; if (got_pop !== exp_pop) begin n_err++; $display("FAIL fullrw_drain got=%h want=%h", got_pop, exp_pop); end
    end
    n_cmp++; if (exp_pop !== 8'h55) begin n_err++; $display("FAIL fullrw_last got=%h want=55", exp_pop); end
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 6; i++) begin
        step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        n_cmp++; if (o_Count !== 4'(sb_q.size())) begin n_err++; $display("FAIL wrap_wcount got=%0d want=%0d", o_Count, sb_q.size()); end
      end
      for (int i = 0; i < 6; i++) begin
        step(1'b0, 8'h00, 1'b1);
        n_cmp++; if (got_pop !== exp_pop || o_Count !== 4'(sb_q.size())) begin
          n_err++; $display("FAIL wrap_read got=%h/%0d want=%h/%0d", got_pop, o_Count, exp_pop, sb_q.size());
        end
      end
    end
    n_cmp++; if (o_Empty !== 1'b1) begin n_err++; $display("FAIL wrap_empty got=%b want=1", o_Empty); end
  endtask

  task automatic test_clr_flush();
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (o_Overrun !== 1'b1 || m_ovr !== 1'b1) begin n_err++; $display("FAIL clr_vs_drop got=%b want=1", o_Overrun); end
    step(1'b1, 8'hBB, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (o_Count !== 4'd0 || o_Empty !== 1'b1 || o_Data !== 8'h00) begin
      n_err++; $display("FAIL flush_state got=%0d/%b/%h want=0/1/00", o_Count, o_Empty, o_Data);
    end
    n_cmp++; if (o_Overrun !== m_ovr) begin n_err++; $display("FAIL flush_ovr got=%b want=%b", o_Overrun, m_ovr); end
    step(1'b1, 8'h77, 1'b0);
    n_cmp++; if (o_Data !== 8'h77 || o_Count !== 4'd1) begin n_err++; $display("FAIL flush_after got=%h/%0d want=77/1", o_Data, o_Count); end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    i_Rx_Done = 1'b1; i_Rx_Data = 8'h33;
    do_reset();
    n_cmp++; if (o_Count !== 4'd0 || o_Empty !== 1'b1 || o_Overrun !== 1'b0 || o_Data !== 8'h00) begin
      n_err++; $display("FAIL midreset got=%0d/%b/%b/%h want=0/1/0/00", o_Count, o_Empty, o_Overrun, o_Data);
    end
    step(1'b1, 8'h44, 1'b0);
    n_cmp++; if (o_Data !== 8'h44) begin n_err++; $display("FAIL midreset_ptr got=%h want=44", o_Data); end
  endtask

  initial begin
    m_ovr = 1'b0;
    test_reset();
    test_basic();
    test_fill_overrun();
    test_full_rw();
    test_wrap();
    test_clr_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
